// File: rtl/gcd_ctrl_pkg.sv
// Shared definitions for the GCD sequencer: state encoding, CTRL8 meanings,
// and the Moore output decode used by the FSM.
package gcd_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      CHECK  = 3'd2,
      SUB_A  = 3'd3,
      SUB_B  = 3'd4,
      OUTPUT = 3'd5,
      DONE   = 3'd6
   } state_t;

   // CTRL8 in SUB states: subtract order
   localparam logic SUB_AB = 1'b0;
   localparam logic SUB_BA = 1'b1;
   // CTRL8 in OUTPUT: result source
   localparam logic SEL_A  = 1'b0;
   localparam logic SEL_B  = 1'b1;

   typedef struct packed {
      logic ctrl3;
      logic ctrl4;
      logic ctrl5;
      logic ctrl8;
      logic ctrl9;
      logic busy;
      logic done;
   } ctrl_t;

   // Moore output decode; sel only matters in OUTPUT.
   function automatic ctrl_t decode(input state_t s, input logic sel);
      ctrl_t c;
      c = '0;
      c.busy = (s != IDLE);
      unique case (s)
         LOAD: begin
            c.ctrl3 = 1'b1;
            c.ctrl4 = 1'b1;
         end
         SUB_A: begin
            c.ctrl3 = 1'b1;
            c.ctrl5 = 1'b1;
            c.ctrl8 = SUB_AB;
         end
         SUB_B: begin
            c.ctrl4 = 1'b1;
            c.ctrl5 = 1'b1;
            c.ctrl8 = SUB_BA;
         end
         OUTPUT: begin
            c.ctrl9 = 1'b1;
            c.ctrl8 = sel;
         end
         DONE:    c.done = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/gcd_iter_counter.sv
// Subtract-iteration counter for the GCD sequencer timeout: clears on load,
// counts SUB cycles, and flags when the count has reached the limit.
module gcd_iter_counter #(
   parameter int           W     = 16,
   parameter logic [W-1:0] LIMIT = '1
) (
   input  logic CLK,
   input  logic RST,
   input  logic clear,
   input  logic inc,
   output logic at_limit
);

   logic [W-1:0] count;

   // Iteration count, synchronous reset and clear
   always_ff @(posedge CLK) begin
      if (RST || clear)
         count <= '0;
      else if (inc)
         count <= count + {{(W-1){1'b0}}, 1'b1};
   end

   assign at_limit = (count == LIMIT);

endmodule

// File: rtl/gcd_controller.sv
// Subtract-based GCD sequencer driving datapath section 3 (CTRL3/4/5/8/9).
// Optional feature macro: GCD_CTRL_TIMEOUT_EN bounds the subtract loop to
// MAX_ITER iterations and reports an aborted run through err.
//
// state  | meaning
// IDLE   | waiting for start, all controls low
// LOAD   | load A and B from the external operands
// CHECK  | evaluate datapath flags, pick next step
// SUB_A  | A <= A - B
// SUB_B  | B <= B - A
// OUTPUT | capture A or B (sel) into the result register
// DONE   | one-cycle completion pulse
module gcd_controller
   import gcd_ctrl_pkg::*;
#(
   parameter int                ITER_W   = 16,
   parameter logic [ITER_W-1:0] MAX_ITER = 16'hFFFF
) (
   input  logic CLK,
   input  logic RST,
   input  logic start,
   input  logic a_eq_b,
   input  logic a_lt_b,
   input  logic a_zero,
   input  logic b_zero,
   output logic CTRL3,
   output logic CTRL4,
   output logic CTRL5,
   output logic CTRL8,
   output logic CTRL9,
   output logic busy,
   output logic done,
   output logic err
);

   state_t state, nxt;
   logic   sel, nxt_sel;
   ctrl_t  ctrl_q;
   logic   at_limit;

`ifdef GCD_CTRL_TIMEOUT_EN
   logic err_q;

   gcd_iter_counter #(
      .W     (ITER_W),
      .LIMIT (MAX_ITER)
   ) u_iter_counter (
      .CLK      (CLK),
      .RST      (RST),
      .clear    (state == LOAD),
      .inc      ((state == SUB_A) || (state == SUB_B)),
      .at_limit (at_limit)
   );

   assign err = err_q;
`else
   // No counter without the timeout: the limit can never trip, and the
   // parameters only shape the timeout build.
   assign at_limit = (ITER_W < 1) && (MAX_ITER == '0);
   assign err      = 1'b0;
`endif

   // Next-state and sel selection; flags only matter in CHECK
   always_comb begin
      nxt     = state;
      nxt_sel = sel;
      unique case (state)
         IDLE:   if (start) nxt = LOAD;
         LOAD:   nxt = CHECK;
         CHECK: begin
            if (a_zero && b_zero) begin
               nxt     = OUTPUT;
               nxt_sel = SEL_A;
            end else if (a_zero) begin
               nxt     = OUTPUT;
               nxt_sel = SEL_B;
            end else if (b_zero || a_eq_b) begin
               nxt     = OUTPUT;
               nxt_sel = SEL_A;
            end else if (at_limit) begin
               nxt     = DONE;
            end else if (a_lt_b) begin
               nxt     = SUB_B;
            end else begin
               nxt     = SUB_A;
            end
         end
         SUB_A:  nxt = CHECK;
         SUB_B:  nxt = CHECK;
         OUTPUT: nxt = DONE;
         DONE:   nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // State register with outputs registered from the next-state decode
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         sel    <= 1'b0;
         ctrl_q <= '0;
`ifdef GCD_CTRL_TIMEOUT_EN
         err_q  <= 1'b0;
`endif
      end else begin
         state  <= nxt;
         sel    <= nxt_sel;
         ctrl_q <= decode(nxt, nxt_sel);
`ifdef GCD_CTRL_TIMEOUT_EN
         // Only an abort jumps CHECK -> DONE; err lives exactly as long as DONE
         err_q  <= (state == CHECK) && (nxt == DONE);
`endif
      end
   end

   assign CTRL3 = ctrl_q.ctrl3;
   assign CTRL4 = ctrl_q.ctrl4;
   assign CTRL5 = ctrl_q.ctrl5;
   assign CTRL8 = ctrl_q.ctrl8;
   assign CTRL9 = ctrl_q.ctrl9;
   assign busy  = ctrl_q.busy;
   assign done  = ctrl_q.done;

endmodule

// File: tb/tb_gcd_controller.sv
// Directed bench for gcd_controller with a small A/B/result datapath model.
module tb_gcd_controller;

   logic CLK = 1'b0;
   logic RST, start;
   logic a_eq_b, a_lt_b, a_zero, b_zero;
   logic CTRL3, CTRL4, CTRL5, CTRL8, CTRL9, busy, done, err;

   logic [15:0] op_a = '0, op_b = '0;
   logic [15:0] ra = '0, rb = '0, res = '0;
   logic [15:0] diff;

   int checks = 0;
   int errors = 0;

   gcd_controller #(.ITER_W(16), .MAX_ITER(16'd4)) dut (
      .CLK(CLK), .RST(RST), .start(start),
      .a_eq_b(a_eq_b), .a_lt_b(a_lt_b), .a_zero(a_zero), .b_zero(b_zero),
      .CTRL3(CTRL3), .CTRL4(CTRL4), .CTRL5(CTRL5), .CTRL8(CTRL8), .CTRL9(CTRL9),
      .busy(busy), .done(done), .err(err)
   );

   always #5 CLK = ~CLK;

   // datapath section model
   assign a_eq_b = (ra == rb);
   assign a_lt_b = (ra < rb);
   assign a_zero = (ra == 16'd0);
   assign b_zero = (rb == 16'd0);
   assign diff   = CTRL8 ? (rb - ra) : (ra - rb);

   always @(posedge CLK) begin
      if (CTRL3) ra <= CTRL5 ? diff : op_a;
      if (CTRL4) rb <= CTRL5 ? diff : op_b;
      if (CTRL9) res <= CTRL8 ? rb : ra;
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full run: start at edge k, then watch until done (bounded).
   task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] exp_res, input int exp_na, input int exp_nb,
                      input logic exp_sel, input logic exp_err);
      int cyc, na, nb, exp_cyc;
      logic c9, s8;
      op_a = a; op_b = b; start = 1'b1;
      tick;
      start = 1'b0;
      cyc = 1; na = 0; nb = 0; c9 = 1'b0; s8 = 1'b0;
      check({tag, "_load"}, {28'd0, CTRL3, CTRL4, CTRL5, busy}, 32'b1101);
      while (!done && cyc < 400) begin
         if (CTRL3 && CTRL5) na++;
         if (CTRL4 && CTRL5) nb++;
         if (CTRL9) begin c9 = 1'b1; s8 = CTRL8; end
         tick;
         cyc++;
      end
      exp_cyc = exp_err ? 3 + 2 * (exp_na + exp_nb) : 4 + 2 * (exp_na + exp_nb);
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_cycle"}, cyc, exp_cyc);
      check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
      check({tag, "_nsub_a"}, na, exp_na);
      check({tag, "_nsub_b"}, nb, exp_nb);
      check({tag, "_ctrl9"}, {31'd0, c9}, {31'd0, ~exp_err});
      if (!exp_err) begin
         check({tag, "_sel"}, {31'd0, s8}, {31'd0, exp_sel});
         check({tag, "_result"}, {16'd0, res}, {16'd0, exp_res});
      end
      tick;
      check({tag, "_after"}, {30'd0, busy, done}, 32'd0);
   endtask

   initial begin
      int last, t, idle_wait;
      RST = 1'b1; start = 1'b0;
      tick; tick;
      check("reset_outputs", {24'd0, CTRL3, CTRL4, CTRL5, CTRL8, CTRL9, busy, done, err}, 32'd0);
      RST = 1'b0;
      tick;
      check("idle_hold", {30'd0, busy, done}, 32'd0);

      run("eq66",  16'd6,  16'd6,  16'd6, 0, 0, 1'b0, 1'b0);
      run("r64",   16'd6,  16'd4,  16'd2, 1, 1, 1'b0, 1'b0);
      run("r216",  16'd21, 16'd6,  16'd3, 3, 1, 1'b0, 1'b0);
      run("z09",   16'd0,  16'd9,  16'd9, 0, 0, 1'b1, 1'b0);
      run("z00",   16'd0,  16'd0,  16'd0, 0, 0, 1'b0, 1'b0);
      run("b0",    16'd7,  16'd0,  16'd7, 0, 0, 1'b0, 1'b0);
`ifdef GCD_CTRL_TIMEOUT_EN
      run("tmo",   16'd1,  16'd100, 16'd0, 0, 4, 1'b0, 1'b1);
`else
      run("long",  16'd1,  16'd100, 16'd1, 0, 99, 1'b0, 1'b0);
`endif

      // start during SUB_A is ignored; RST in CHECK aborts with no done
      op_a = 16'd6; op_b = 16'd4; start = 1'b1;
      tick;                      // LOAD
      start = 1'b0;
      tick;                      // CHECK
      tick;                      // SUB_A
      check("ign_sub_a", {29'd0, CTRL3, CTRL5, CTRL8}, 32'b110);
      start = 1'b1;
      tick;                      // CHECK
      start = 1'b0;
      check("ign_check", {24'd0, CTRL3, CTRL4, CTRL5, CTRL8, CTRL9, busy, done, err}, 32'b0000_0100);
      tick;                      // SUB_B
      check("ign_sub_b", {28'd0, CTRL4, CTRL5, CTRL8, busy}, 32'b1111);
      tick;                      // CHECK
      RST = 1'b1;
      tick;
      RST = 1'b0;
      check("rst_mid", {24'd0, CTRL3, CTRL4, CTRL5, CTRL8, CTRL9, busy, done, err}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick;
         check("rst_quiet", {30'd0, busy, done}, 32'd0);
      end

      // start held high: back-to-back runs, done every 5 cycles
      op_a = 16'd3; op_b = 16'd3; start = 1'b1;
      last = -1;
      for (t = 1; t <= 22; t++) begin
         tick;
         if (done) begin
            if (last < 0) check("b2b_first", t, 4);
            else          check("b2b_spacing", t - last, 5);
            check("b2b_result", {16'd0, res}, 32'd3);
            last = t;
         end
      end
      check("b2b_seen", (last > 0) ? 32'd1 : 32'd0, 32'd1);
      start = 1'b0;
      idle_wait = 0;
      while (busy && idle_wait < 10) begin
         tick;
         idle_wait++;
      end
      check("b2b_drain", {31'd0, busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gcd_controller.md
# gcd_controller

Sequencer that sits directly upstream of datapath section 3 and drives its CTRL3/CTRL4/CTRL5/CTRL8/CTRL9 lines. It runs the subtract-based iterative GCD loop on the section's A/B registers. It accepts a start request, steers load, subtract and output-capture cycles from the datapath's status flags, and signals completion with a one-cycle `done` pulse.

## Interface
- `ITER_W`, 16: width of the iteration counter.
- `MAX_ITER`, 16'hFFFF: maximum subtract iterations before abort. Used only with the timeout feature.
- `CLK` in 1: sole clock; all state changes on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `start` in 1: begin a GCD run; sampled only in IDLE.
- `a_eq_b` in 1: datapath status, A == B.
- `a_lt_b` in 1: datapath status, A < B (unsigned).
- `a_zero` in 1: datapath status, A == 0.
- `b_zero` in 1: datapath status, B == 0.
- `CTRL3` out 1: load enable, register A.
- `CTRL4` out 1: load enable, register B.
- `CTRL5` out 1: A/B input mux select; 0 = external operand, 1 = subtractor result.
- `CTRL8` out 1: in SUB states, subtract order (0 = A−B, 1 = B−A); in OUTPUT, result source (0 = A, 1 = B).
- `CTRL9` out 1: result register load enable.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; run aborted by timeout.

## Operation
- Moore FSM; all outputs decode from the state register only. The status flags steer only transitions out of CHECK.
- IDLE: all CTRL = 0. If `start` = 1 → LOAD.
- LOAD: CTRL3 = CTRL4 = 1, CTRL5 = 0. Next state is CHECK.
- CHECK: all CTRL = 0. Flags are evaluated with this priority:
  - `a_zero` & `b_zero` → OUTPUT, sel = 0 (result 0).
  - `a_zero` → OUTPUT, sel = 1.
  - `b_zero` → OUTPUT, sel = 0.
  - `a_eq_b` → OUTPUT, sel = 0.
  - `a_lt_b` → SUB_B.
  - otherwise → SUB_A.
  - The `sel` bit is registered on the CHECK exit.
- SUB_A: CTRL3 = 1, CTRL5 = 1, CTRL8 = 0 (A ← A−B). Next state is CHECK.
- SUB_B: CTRL4 = 1, CTRL5 = 1, CTRL8 = 1 (B ← B−A). Next state is CHECK.
- OUTPUT: CTRL9 = 1, CTRL8 = sel. Next state is DONE.
- DONE: `done` = 1 for exactly one cycle. Next state is IDLE.
- `start` is ignored while busy and is never queued.
- `start` is level-sensitive in IDLE: if it is still high on return to IDLE, a new run begins.
- Reset values: state = IDLE; all CTRL, `busy`, `done` and `err` = 0; sel = 0; iteration counter = 0.
- Reset mid-run: IDLE on the next edge and all outputs low. No `done` pulse is issued. Datapath register contents are not this block's concern.

## Timing
- `start` sampled high at edge k: LOAD during cycle k+1, first CHECK during cycle k+2.
- Each subtract iteration adds 2 cycles (SUB + CHECK).
- With N iterations, `done` is high during cycle k+4+2N.
- The result register captures at the edge that ends OUTPUT, one cycle before `done`.
- `busy` rises in cycle k+1 and falls in the cycle after DONE.
- Minimum start-to-start spacing is 5 cycles (N = 0).

## Configuration
- `GCD_CTRL_TIMEOUT_EN` defined:
  - An ITER_W-bit counter clears in LOAD and increments on each SUB state.
  - In CHECK, if a subtract branch is selected and count == MAX_ITER, the FSM goes to DONE with `err` = 1.
  - OUTPUT is skipped, so CTRL9 never asserts for an aborted run.
  - `err` clears on leaving DONE.
- `GCD_CTRL_TIMEOUT_EN` undefined: no counter is built, `err` is tied to 0, and loops are unbounded.

## Structure
- Shared package `gcd_ctrl_pkg` holds:
  - the state encoding (IDLE, LOAD, CHECK, SUB_A, SUB_B, OUTPUT, DONE) as 3-bit constants;
  - the CTRL8 meaning constants (SUB_AB, SUB_BA, SEL_A, SEL_B).
- One sub-module, `gcd_iter_counter`, with clear, increment and limit-compare. It is instantiated only under `GCD_CTRL_TIMEOUT_EN`.

## Test plan
- Flags model A = 6, B = 6, `start` pulsed at edge k → LOAD, CHECK, OUTPUT with CTRL8 = 0, `done` in cycle k+4, result 6, `err` = 0.
- A = 6, B = 4 → SUB_A (A = 2), then SUB_B (B = 2), then OUTPUT; `done` in cycle k+8, result 2.
- A = 0, B = 9 → OUTPUT with CTRL8 = 1, result 9. A = 0, B = 0 → result 0, with no SUB states in either case.
- `start` reasserted during SUB_A, and `RST` asserted in CHECK → the first `start` is ignored with no state disturbance; after `RST`, IDLE on the next edge with all outputs 0 and no `done`.
- `GCD_CTRL_TIMEOUT_EN` defined, MAX_ITER = 4, A = 1, B = 100 → exactly 4 SUB_B cycles, then `done` = 1 and `err` = 1; CTRL9 never high.
- `start` held high continuously with A = B = 3 → back-to-back runs, with `done` every 5 cycles.
